// File: rtl/midi_tx_scheduler.sv
// midi_tx_scheduler: round-robin MIDI message arbiter with real-time byte insertion and running status
module midi_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int RUN_STATUS = 1,
  parameter int PULSE_LEN  = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*24-1:0] req_msg,
  input  logic [NREQ*2-1:0] req_len,
  output logic [NREQ-1:0]   req_done,
  input  logic              rt_valid,
  input  logic [7:0]        rt_byte,
  output logic              rt_done,
  input  logic              midi_out_ready,
  output logic              midi_send_byte,
  output logic [7:0]        midi_out_data,
  output logic              busy,
  output logic              tx_timeout
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + PULSE_LEN + 1);
  typedef enum logic [2:0] {IDLE, SELECT, STROBE, WAIT_BUSY, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, grant, gnt, rr_j;
  logic gnt_ok, in_msg, is_rt, skip, eff_rt;
  logic [NREQ-1:0] eff_valid;
  logic [23:0] msg, gmsg, sel_msg;
  logic [1:0] idx, lst, glen, lst_n, sel_idx;
  logic [7:0] last_status, sel_byte;
  logic [CW-1:0] cnt;
  // a requester whose done pulse is showing this cycle has not yet had the chance to drop its request
  assign eff_valid = req_valid & ~req_done;
  assign eff_rt = rt_valid & ~rt_done;
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    rr_j = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_j = PW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_ok && eff_valid[rr_j]) begin
        gnt_ok = 1'b1;
        gnt = rr_j;
      end
    end
  end
  assign gmsg = req_msg[24*gnt +: 24];
  assign glen = req_len[2*gnt +: 2];
  assign lst_n = (glen == 2'd0) ? 2'd0 : glen - 2'd1;
  assign skip = (RUN_STATUS != 0) && gmsg[23:16] >= 8'h80 && gmsg[23:16] <= 8'hEF &&
                gmsg[23:16] == last_status && lst_n != 2'd0;
  assign sel_msg = in_msg ? msg : gmsg;
  assign sel_idx = in_msg ? idx : {1'b0, skip};
  assign sel_byte = (sel_idx == 2'd0) ? sel_msg[23:16] : (sel_idx == 2'd1) ? sel_msg[15:8] : sel_msg[7:0];
  assign midi_send_byte = state == STROBE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = ((eff_rt || |eff_valid) && midi_out_ready) ? SELECT : IDLE;
      SELECT:    state_n = (eff_rt || in_msg || gnt_ok) ? STROBE : IDLE;
      STROBE:    state_n = (cnt == CW'(PULSE_LEN - 1)) ? WAIT_BUSY : STROBE;
      WAIT_BUSY: state_n = !midi_out_ready ? WAIT_IDLE : (cnt == CW'(TIMEOUT - 1)) ? SELECT : WAIT_BUSY;
      WAIT_IDLE: state_n = midi_out_ready ? SELECT : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      msg <= '0;
      idx <= '0;
      lst <= '0;
      in_msg <= 1'b0;
      is_rt <= 1'b0;
      cnt <= '0;
      last_status <= 8'h00;
      midi_out_data <= 8'h00;
      req_done <= '0;
      rt_done <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state <= state_n;
      req_done <= '0;
      rt_done <= 1'b0;
      tx_timeout <= 1'b0;
      cnt <= (state_n == state) ? cnt + 1'b1 : '0;
      if (state == SELECT && state_n == STROBE) begin
        midi_out_data <= eff_rt ? rt_byte : sel_byte;
        is_rt <= eff_rt;
        if (!eff_rt && !in_msg) begin
          grant <= gnt;
          rr_ptr <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          msg <= gmsg;
          lst <= lst_n;
          idx <= {1'b0, skip};
          in_msg <= 1'b1;
        end
      end
      if (state == WAIT_BUSY && state_n == SELECT) begin
        tx_timeout <= 1'b1;
        last_status <= 8'h00;
        if (is_rt) rt_done <= 1'b1;
        else begin
          req_done[grant] <= 1'b1;
          in_msg <= 1'b0;
        end
      end
      if (state == WAIT_IDLE && midi_out_ready) begin
        if (is_rt) rt_done <= 1'b1;
        else begin
          if (idx == 2'd0)
            last_status <= (midi_out_data >= 8'h80 && midi_out_data <= 8'hEF) ? midi_out_data :
                           (midi_out_data >= 8'hF0) ? 8'h00 : last_status;
          if (idx == lst) begin
            in_msg <= 1'b0;
            req_done[grant] <= 1'b1;
          end else idx <= idx + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_tx_scheduler.sv
// tb_midi_tx_scheduler: scoreboard bench with a behavioural UART for midi_tx_scheduler
module tb_midi_tx_scheduler;
  localparam int NREQ = 4, PULSE_LEN = 4, TIMEOUT = 1024;
  // UART frame timing shortened so the whole run stays small
  localparam int FALL_DLY = 20, BUSY_DLY = 60;
  logic CLOCK_25 = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*24-1:0] req_msg = '0;
  logic [NREQ*2-1:0] req_len = '0;
  logic [NREQ-1:0] req_done;
  logic rt_valid = 1'b0;
  logic [7:0] rt_byte = 8'h00;
  logic rt_done;
  logic midi_out_ready = 1'b1;
  logic midi_send_byte;
  logic [7:0] midi_out_data;
  logic busy, tx_timeout;
  int checks = 0, failures = 0;
  int cyc = 0, sent = 0, strobe_cyc = 0, to_cyc = 0, to_cnt = 0, rt_cnt = 0, uphase = 0, ucnt = 0;
  int done_cnt[NREQ];
  int done_q[$];
  logic [7:0] exp_q[$];
  bit prev_send = 1'b0, uart_dead = 1'b0, persist = 1'b0;

  midi_tx_scheduler #(.NREQ(NREQ), .RUN_STATUS(1), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .req_valid(req_valid), .req_msg(req_msg), .req_len(req_len),
    .req_done(req_done), .rt_valid(rt_valid), .rt_byte(rt_byte), .rt_done(rt_done),
    .midi_out_ready(midi_out_ready), .midi_send_byte(midi_send_byte), .midi_out_data(midi_out_data),
    .busy(busy), .tx_timeout(tx_timeout));

  always #20 CLOCK_25 = ~CLOCK_25;

  task automatic tick();
    logic [7:0] e;
    @(negedge CLOCK_25);
    cyc++;
    if (uphase != 0) begin
      ucnt--;
      if (ucnt == 0) begin
        if (uphase == 1) begin
          midi_out_ready = 1'b0;
          uphase = 2;
          ucnt = BUSY_DLY;
        end else begin
          midi_out_ready = 1'b1;
          uphase = 0;
        end
      end
    end
    if (midi_send_byte === 1'b1 && !prev_send) begin
      sent++;
      strobe_cyc = cyc;
      if (!uart_dead) begin
        uphase = 1;
        ucnt = FALL_DLY;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL byte_order: sent %h, no byte expected", midi_out_data);
      end else begin
        e = exp_q.pop_front();
        if (midi_out_data !== e) begin
          failures++;
          $display("FAIL byte_order: sent %h, expected %h", midi_out_data, e);
        end
      end
    end
    prev_send = (midi_send_byte === 1'b1);
    for (int i = 0; i < NREQ; i++)
      if (req_done[i] === 1'b1) begin
        done_cnt[i]++;
        done_q.push_back(i);
        if (!persist) req_valid[i] = 1'b0;
      end
    if (rt_done === 1'b1) begin
      rt_cnt++;
      rt_valid = 1'b0;
    end
    if (tx_timeout === 1'b1) begin
      to_cnt++;
      to_cyc = cyc;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    done_q.delete();
    exp_q.delete();
    rt_cnt = 0;
    to_cnt = 0;
    sent = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    rt_valid = 1'b0;
    uphase = 0;
    midi_out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic set_req(input int i, input logic [23:0] m, input logic [1:0] len);
    req_msg[24*i +: 24] = m;
    req_len[2*i +: 2] = len;
    req_valid[i] = 1'b1;
  endtask

  task automatic push3(input logic [23:0] m);
    exp_q.push_back(m[23:16]);
    exp_q.push_back(m[15:8]);
    exp_q.push_back(m[7:0]);
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && (busy !== 1'b0 || req_valid != '0 || rt_valid)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (midi_send_byte !== 1'b0) begin failures++; $display("FAIL reset_send: got %b, expected 0", midi_send_byte); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (req_done !== '0) begin failures++; $display("FAIL reset_req_done: got %b, expected 0", req_done); end
    if (rt_done !== 1'b0) begin failures++; $display("FAIL reset_rt_done: got %b, expected 0", rt_done); end
    if (tx_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b, expected 0", tx_timeout); end
    if (midi_out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h, expected 00", midi_out_data); end
  endtask

  task automatic test_single();
    push3(24'h903C64);
    set_req(0, 24'h903C64, 2'd3);
    run_until_idle("single", 5000);
    checks += 3;
    if (done_cnt[0] != 1) begin failures++; $display("FAIL single_done: got %0d pulses, expected 1", done_cnt[0]); end
    if (sent != 3) begin failures++; $display("FAIL single_count: got %0d bytes, expected 3", sent); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  task automatic test_running_status();
    clear_counts();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h50);
    set_req(1, 24'h904050, 2'd3);
    run_until_idle("runstat_skip", 5000);
    push3(24'hB0077F);
    set_req(1, 24'hB0077F, 2'd3);
    run_until_idle("runstat_new", 5000);
    checks += 3;
    if (done_cnt[1] != 2) begin failures++; $display("FAIL runstat_done: got %0d pulses, expected 2", done_cnt[1]); end
    if (sent != 5) begin failures++; $display("FAIL runstat_count: got %0d bytes, expected 5", sent); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL runstat_missing: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    logic [7:0] k;
    apply_reset();
    persist = 1'b1;
    for (int g = 0; g < 5; g++) begin
      k = 8'(g % NREQ);
      push3({8'h90 + k, 8'h10 + k, 8'h20 + k});
    end
    for (int i = 0; i < NREQ; i++) begin
      k = 8'(i);
      set_req(i, {8'h90 + k, 8'h10 + k, 8'h20 + k}, 2'd3);
    end
    while (done_q.size() < 5 && n < 20000) begin
      tick();
      n++;
    end
    req_valid = '0;
    persist = 1'b0;
    run_until_idle("rr", 5000);
    checks += 2;
    if (done_q.size() != 5) begin failures++; $display("FAIL rr_grants: got %0d grants, expected 5", done_q.size()); end
    else for (int g = 0; g < 5; g++) begin
      checks++;
      if (done_q[g] != g % NREQ) begin failures++; $display("FAIL rr_order: grant %0d went to %0d, expected %0d", g, done_q[g], g % NREQ); end
    end
    if (exp_q.size() != 0) begin failures++; $display("FAIL rr_missing: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  task automatic test_rt_insert();
    int n = 0;
    apply_reset();
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h3C);
    set_req(0, 24'h903C64, 2'd3);
    while (sent < 2 && n < 5000) begin
      tick();
      n++;
    end
    rt_byte = 8'hF8;
    rt_valid = 1'b1;
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'h64);
    run_until_idle("rt_msg", 5000);
    exp_q.push_back(8'h3D);
    exp_q.push_back(8'h00);
    set_req(2, 24'h903D00, 2'd3);
    run_until_idle("rt_after", 5000);
    checks += 4;
    if (rt_cnt != 1) begin failures++; $display("FAIL rt_done: got %0d pulses, expected 1", rt_cnt); end
    if (done_cnt[0] != 1) begin failures++; $display("FAIL rt_req_done: got %0d pulses, expected 1", done_cnt[0]); end
    if (sent != 6) begin failures++; $display("FAIL rt_count: got %0d bytes, expected 6", sent); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL rt_missing: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int n = 0, d;
    apply_reset();
    uart_dead = 1'b1;
    exp_q.push_back(8'h90);
    push3(24'h900304);
    set_req(0, 24'h900102, 2'd3);
    set_req(1, 24'h900304, 2'd3);
    while (to_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    d = to_cyc - strobe_cyc;
    uart_dead = 1'b0;
    run_until_idle("timeout", 5000);
    checks += 5;
    if (to_cnt != 1) begin failures++; $display("FAIL to_pulse: got %0d pulses, expected 1", to_cnt); end
    if (d != TIMEOUT + PULSE_LEN) begin failures++; $display("FAIL to_delay: got %0d cycles, expected %0d", d, TIMEOUT + PULSE_LEN); end
    if (done_cnt[0] != 1) begin failures++; $display("FAIL to_req_done: got %0d pulses, expected 1", done_cnt[0]); end
    if (done_cnt[1] != 1) begin failures++; $display("FAIL to_next_done: got %0d pulses, expected 1", done_cnt[1]); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL to_missing: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    push3(24'h901122);
    set_req(0, 24'h901122, 2'd3);
    while (!(sent == 2 && midi_out_ready == 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    if (midi_send_byte !== 1'b0) begin failures++; $display("FAIL midreset_send: got %b, expected 0", midi_send_byte); end
    reset = 1'b0;
    req_valid = '0;
    exp_q.delete();
    repeat (5) tick();
    checks++;
    if (done_cnt[0] != 0 || rt_cnt != 0) begin failures++; $display("FAIL midreset_done: got %0d/%0d pulses, expected 0/0", done_cnt[0], rt_cnt); end
    push3(24'h903344);
    set_req(0, 24'h903344, 2'd3);
    run_until_idle("midreset", 5000);
    checks += 3;
    if (done_cnt[0] != 1) begin failures++; $display("FAIL midreset_next_done: got %0d pulses, expected 1", done_cnt[0]); end
    if (sent != 5) begin failures++; $display("FAIL midreset_count: got %0d bytes, expected 5", sent); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_missing: %0d bytes unsent, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_running_status();
    test_round_robin();
    test_rt_insert();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
